// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the LEGv8 memory-port arbiter:
//   - arb_state_e      : arbiter state (IDLE, BUSY_IF, BUSY_D, DONE)
//   - OWN_IF / OWN_D   : encoding of the current access owner
//   - DEF_TIMEOUT_CYC  : default BUSY-cycle budget before an access is aborted
//   - DEF_STARVE_MAX   : default fetch losses before fetch is forced to win
//   - sat_inc32        : saturating increment used by the optional perf counters
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2,
    DONE    = 2'd3
  } arb_state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  localparam int DEF_TIMEOUT_CYC = 16;
  localparam int DEF_STARVE_MAX  = 3;

  // Increment that sticks at all-ones instead of wrapping to zero.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    if (value == 32'hFFFF_FFFF) begin
      return value;
    end else begin
      return value + 32'd1;
    end
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the two requester handshakes (fetch, data) and the unified memory
// port of the arbiter.
//   slave  modport : the arbiter's view (requests + memory response in,
//                    completions + memory command out)
//   master modport : the environment's view (control unit + memory model)
// Parameters: ADDR_W (address width), DATA_W (data width).
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);

  // fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_rdata;
  logic              if_done;

  // data requester
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;

  // memory port
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  // status
  logic              timeout_err;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_rdata, if_done, d_rdata, d_done,
    output mem_en, mem_we, mem_addr, mem_wdata, timeout_err
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_done, d_rdata, d_done,
    input  mem_en, mem_we, mem_addr, mem_wdata, timeout_err
  );

endinterface

// File: rtl/mem_arb_wait_counter.sv
// ---------------------------------------------------------------------------
// mem_arb_wait_counter
// Counts BUSY cycles of the current access and flags the last allowed one.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   clr          : synchronous clear (held while no access is in flight)
//   en           : count enable (one per BUSY cycle)
//   timeout_hit  : high during the BUSY cycle whose count is TIMEOUT_CYC-1,
//                  i.e. the final cycle in which mem_ready is still accepted
// ---------------------------------------------------------------------------
module mem_arb_wait_counter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic timeout_hit
);

  localparam int              CNT_W   = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_r;

  // Wait counter: cleared between accesses, stops at the last allowed value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en && (cnt_r != CNT_LAST)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign timeout_hit = en && (cnt_r == CNT_LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single memory port of the multi-cycle LEGv8 core between the
// instruction-fetch path and the load/store path. Each access is latched at
// grant, held on the port until mem_ready (or a timeout), and completed with
// a one-cycle done pulse to its owner; every access ends with a DONE cycle
// followed by an IDLE cycle.
// Ports:
//   clock  : system clock, rising edge
//   reset  : asynchronous active-low reset
//   bus    : mem_port_arbiter_if.slave (requesters, memory port, timeout_err)
// Optional feature (macro MEM_PORT_ARBITER_PERF_EN): adds saturating
//   perf_if_grants, perf_d_grants and perf_wait_cycles outputs.
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int STARVE_MAX  = DEF_STARVE_MAX,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clock,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
`ifdef MEM_PORT_ARBITER_PERF_EN
  ,
  output logic [31:0]       perf_if_grants,
  output logic [31:0]       perf_d_grants,
  output logic [31:0]       perf_wait_cycles
`endif
);

  localparam int                STARVE_W   = $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
  localparam logic [STARVE_W-1:0] STARVE_ONE = {{(STARVE_W-1){1'b0}}, 1'b1};

  arb_state_e          state_r, state_s;
  logic                grant_if_s, grant_d_s, fetch_wins_s;
  logic                busy_s, finish_s, timeout_s, timeout_hit_s;

  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic                we_r, we_s;
  logic [DATA_W-1:0]   wdata_r, wdata_s;
  logic                owner_r, owner_s;
  logic [STARVE_W-1:0] starve_cnt_r, starve_s;

  logic                mem_en_r, mem_en_s;
  logic                mem_we_r, mem_we_s;
  logic                if_done_r, if_done_s;
  logic                d_done_r, d_done_s;
  logic [31:0]         if_rdata_r, if_rdata_s;
  logic [DATA_W-1:0]   d_rdata_r, d_rdata_s;
  logic                timeout_err_r, timeout_err_s;

  assign busy_s = (state_r == BUSY_IF) || (state_r == BUSY_D);

  // Fetch beats data only once it has lost STARVE_MAX arbitrations in a row.
  assign fetch_wins_s = bus.if_req && (!bus.d_req || (starve_cnt_r == STARVE_LIM));

  // An access ends on mem_ready, or on its last allowed cycle without it.
  assign finish_s  = busy_s && (bus.mem_ready || timeout_hit_s);
  assign timeout_s = busy_s && !bus.mem_ready && timeout_hit_s;

  mem_arb_wait_counter #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wait_counter (
    .clk         (clock),
    .rst_n       (reset),
    .clr         (!busy_s),
    .en          (busy_s),
    .timeout_hit (timeout_hit_s)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic and grant decode.
  always_comb begin
    state_s    = state_r;
    grant_if_s = 1'b0;
    grant_d_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (fetch_wins_s) begin
          grant_if_s = 1'b1;
          state_s    = BUSY_IF;
        end else if (bus.d_req) begin
          grant_d_s  = 1'b1;
          state_s    = BUSY_D;
        end else begin
          state_s    = IDLE;
        end
      end
      BUSY_IF, BUSY_D: begin
        if (finish_s) begin
          state_s = DONE;
        end else begin
          state_s = state_r;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output logic: next values of the latched command and the registered outputs.
  always_comb begin
    addr_s   = addr_r;
    we_s     = we_r;
    wdata_s  = wdata_r;
    owner_s  = owner_r;
    starve_s = starve_cnt_r;
    if (grant_if_s) begin
      addr_s   = bus.if_addr;
      we_s     = 1'b0;
      wdata_s  = '0;
      owner_s  = OWN_IF;
      starve_s = '0;
    end else if (grant_d_s) begin
      addr_s  = bus.d_addr;
      we_s    = bus.d_we;
      wdata_s = bus.d_wdata;
      owner_s = OWN_D;
      if (bus.if_req && (starve_cnt_r != STARVE_LIM)) begin
        starve_s = starve_cnt_r + STARVE_ONE;
      end else begin
        starve_s = starve_cnt_r;
      end
    end else begin
      starve_s = starve_cnt_r;
    end

    mem_en_s  = (state_s == BUSY_IF) || (state_s == BUSY_D);
    mem_we_s  = (state_s == BUSY_D) && we_s;
    if_done_s = finish_s && (owner_r == OWN_IF);
    d_done_s  = finish_s && (owner_r == OWN_D);

    // A timed-out access returns zero; stores never touch d_rdata.
    if_rdata_s = if_rdata_r;
    d_rdata_s  = d_rdata_r;
    if (if_done_s) begin
      if (timeout_s) begin
        if_rdata_s = 32'h0000_0000;
      end else begin
        if_rdata_s = bus.mem_rdata[31:0];
      end
    end else if (d_done_s && !we_r) begin
      if (timeout_s) begin
        d_rdata_s = '0;
      end else begin
        d_rdata_s = bus.mem_rdata;
      end
    end else begin
      d_rdata_s = d_rdata_r;
    end

    timeout_err_s = timeout_err_r || timeout_s;
  end

  // Command, arbitration and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_r        <= '0;
      we_r          <= 1'b0;
      wdata_r       <= '0;
      owner_r       <= OWN_IF;
      starve_cnt_r  <= '0;
      mem_en_r      <= 1'b0;
      mem_we_r      <= 1'b0;
      if_done_r     <= 1'b0;
      d_done_r      <= 1'b0;
      if_rdata_r    <= 32'h0000_0000;
      d_rdata_r     <= '0;
      timeout_err_r <= 1'b0;
    end else begin
      addr_r        <= addr_s;
      we_r          <= we_s;
      wdata_r       <= wdata_s;
      owner_r       <= owner_s;
      starve_cnt_r  <= starve_s;
      mem_en_r      <= mem_en_s;
      mem_we_r      <= mem_we_s;
      if_done_r     <= if_done_s;
      d_done_r      <= d_done_s;
      if_rdata_r    <= if_rdata_s;
      d_rdata_r     <= d_rdata_s;
      timeout_err_r <= timeout_err_s;
    end
  end

  assign bus.mem_en      = mem_en_r;
  assign bus.mem_we      = mem_we_r;
  assign bus.mem_addr    = addr_r;
  assign bus.mem_wdata   = wdata_r;
  assign bus.if_done     = if_done_r;
  assign bus.if_rdata    = if_rdata_r;
  assign bus.d_done      = d_done_r;
  assign bus.d_rdata     = d_rdata_r;
  assign bus.timeout_err = timeout_err_r;

`ifdef MEM_PORT_ARBITER_PERF_EN
  logic [31:0] perf_if_r, perf_d_r, perf_wait_r;

  // Saturating grant and stall counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_if_r   <= 32'd0;
      perf_d_r    <= 32'd0;
      perf_wait_r <= 32'd0;
    end else begin
      if (grant_if_s) begin
        perf_if_r <= sat_inc32(perf_if_r);
      end else begin
        perf_if_r <= perf_if_r;
      end
      if (grant_d_s) begin
        perf_d_r <= sat_inc32(perf_d_r);
      end else begin
        perf_d_r <= perf_d_r;
      end
      if (busy_s && !bus.mem_ready) begin
        perf_wait_r <= sat_inc32(perf_wait_r);
      end else begin
        perf_wait_r <= perf_wait_r;
      end
    end
  end

  assign perf_if_grants   = perf_if_r;
  assign perf_d_grants    = perf_d_r;
  assign perf_wait_cycles = perf_wait_r;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed scenarios with literal expectations, then randomized traffic; an
// access-level reference model predicts every DUT output each cycle.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int SMAX = 3;
  localparam int TMO  = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  mem_port_arbiter #(
    .ADDR_W(64), .DATA_W(64), .STARVE_MAX(SMAX), .TIMEOUT_CYC(TMO)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  bit model_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one in-flight access, its done cycle, and the starve tally.
  bit          m_busy, m_in_done, m_owner_d, m_we, m_tmo;
  logic [63:0] m_addr, m_wdata, m_d_rdata;
  logic [31:0] m_if_rdata;
  int          m_waited, m_starve;
  bit          m_if_done, m_d_done, m_terr;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_busy = 0; m_in_done = 0; m_owner_d = 0; m_we = 0; m_tmo = 0;
      m_addr = 64'd0; m_wdata = 64'd0; m_d_rdata = 64'd0; m_if_rdata = 32'd0;
      m_waited = 0; m_starve = 0; m_if_done = 0; m_d_done = 0; m_terr = 0;
    end else begin
      m_if_done = 0;
      m_d_done  = 0;
      if (m_in_done) begin
        m_in_done = 0;                       // the mandatory idle cycle follows
      end else if (m_busy) begin
        if (bus.mem_ready || m_waited == TMO - 1) begin
          m_tmo = !bus.mem_ready;
          if (m_tmo) m_terr = 1;
          if (m_owner_d) begin
            m_d_done = 1;
            if (!m_we) m_d_rdata = m_tmo ? 64'd0 : bus.mem_rdata;
          end else begin
            m_if_done = 1;
            m_if_rdata = m_tmo ? 32'd0 : bus.mem_rdata[31:0];
          end
          m_busy = 0;
          m_in_done = 1;
        end else begin
          m_waited++;
        end
      end else if (bus.if_req && (!bus.d_req || m_starve == SMAX)) begin
        m_busy = 1; m_owner_d = 0; m_we = 0; m_addr = bus.if_addr; m_waited = 0;
        m_starve = 0;
      end else if (bus.d_req) begin
        if (bus.if_req && m_starve < SMAX) m_starve++;
        m_busy = 1; m_owner_d = 1; m_we = bus.d_we; m_addr = bus.d_addr;
        m_wdata = bus.d_wdata; m_waited = 0;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clock) begin
    if (model_on) begin
      chk("mdl mem_en", {63'd0, bus.mem_en}, {63'd0, m_busy});
      chk("mdl mem_we", {63'd0, bus.mem_we}, {63'd0, m_busy & m_we});
      if (m_busy) chk("mdl mem_addr", bus.mem_addr, m_addr);
      if (m_busy && m_we) chk("mdl mem_wdata", bus.mem_wdata, m_wdata);
      chk("mdl if_done", {63'd0, bus.if_done}, {63'd0, m_if_done});
      chk("mdl d_done", {63'd0, bus.d_done}, {63'd0, m_d_done});
      chk("mdl if_rdata", {32'd0, bus.if_rdata}, {32'd0, m_if_rdata});
      chk("mdl d_rdata", bus.d_rdata, m_d_rdata);
      chk("mdl timeout_err", {63'd0, bus.timeout_err}, {63'd0, m_terr});
    end
  end

  logic [63:0] seen_q[$];
  int          n_busy;
  bit          got_done;
  int          mode;

  initial begin
    bus.if_req = 1'b0; bus.if_addr = 64'd0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    bus.d_addr = 64'd0; bus.d_wdata = 64'd0; bus.mem_rdata = 64'd0; bus.mem_ready = 1'b0;
    repeat (3) @(negedge clock);
    model_on = 1'b1;
    chk("rst mem_en", {63'd0, bus.mem_en}, 64'd0);
    chk("rst if_done", {63'd0, bus.if_done}, 64'd0);
    chk("rst d_rdata", bus.d_rdata, 64'd0);
    chk("rst timeout_err", {63'd0, bus.timeout_err}, 64'd0);
    reset = 1'b1;

    // Fetch only: ready on the second BUSY cycle.
    @(negedge clock);
    bus.if_req = 1'b1; bus.if_addr = 64'h40;
    @(negedge clock);
    chk("fetch en c1", {63'd0, bus.mem_en}, 64'd1);
    chk("fetch addr", bus.mem_addr, 64'h40);
    bus.if_addr = 64'h999;
    @(negedge clock);
    chk("fetch en c2", {63'd0, bus.mem_en}, 64'd1);
    chk("fetch addr held", bus.mem_addr, 64'h40);
    bus.mem_ready = 1'b1; bus.mem_rdata = 64'h0000_0000_D600_0002;
    @(negedge clock);
    chk("fetch done", {63'd0, bus.if_done}, 64'd1);
    chk("fetch rdata", {32'd0, bus.if_rdata}, 64'hD600_0002);
    chk("fetch en off", {63'd0, bus.mem_en}, 64'd0);
    bus.if_req = 1'b0; bus.mem_ready = 1'b0; bus.mem_rdata = 64'h1111_2222_3333_4444;
    @(negedge clock);
    chk("fetch done 1cyc", {63'd0, bus.if_done}, 64'd0);
    chk("fetch rdata hold", {32'd0, bus.if_rdata}, 64'hD600_0002);

    // Simultaneous requests: the store goes first.
    bus.if_req = 1'b1; bus.if_addr = 64'h48;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 64'h100; bus.d_wdata = 64'hAA;
    @(negedge clock);
    chk("sim we", {63'd0, bus.mem_we}, 64'd1);
    chk("sim addr", bus.mem_addr, 64'h100);
    chk("sim wdata", bus.mem_wdata, 64'hAA);
    bus.mem_ready = 1'b1;
    @(negedge clock);
    chk("sim d_done", {63'd0, bus.d_done}, 64'd1);
    chk("sim store keeps d_rdata", bus.d_rdata, 64'd0);
    bus.d_req = 1'b0;
    @(negedge clock);
    chk("sim idle gap", {63'd0, bus.mem_en}, 64'd0);
    @(negedge clock);
    chk("sim fetch addr", bus.mem_addr, 64'h48);
    chk("sim fetch we", {63'd0, bus.mem_we}, 64'd0);
    @(negedge clock);
    chk("sim if_rdata", {32'd0, bus.if_rdata}, 64'h3333_4444);
    bus.if_req = 1'b0;
    @(negedge clock);

    // Starvation: data held, fetch wins after three losses.
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 64'h200;
    bus.if_req = 1'b1; bus.if_addr = 64'h300;
    bus.mem_ready = 1'b1; bus.mem_rdata = 64'hCAFE_F00D_1234_5678;
    for (int i = 0; i < 24; i++) begin
      @(negedge clock);
      if (bus.mem_en) seen_q.push_back(bus.mem_addr);
      if (bus.if_done) bus.if_req = 1'b0;
    end
    bus.d_req = 1'b0;
    repeat (4) @(negedge clock);
    chk("starve count", 64'(seen_q.size()), 64'd8);
    for (int i = 0; i < 5 && i < seen_q.size(); i++)
      chk("starve order", seen_q[i], (i == 3) ? 64'h300 : 64'h200);
    chk("starve d_rdata", bus.d_rdata, 64'hCAFE_F00D_1234_5678);

    // Timeout: load with mem_ready stuck low.
    bus.mem_ready = 1'b0; bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 64'h208;
    n_busy = 0; got_done = 1'b0;
    for (int i = 0; i < 40 && !got_done; i++) begin
      @(negedge clock);
      if (bus.d_done) got_done = 1'b1;
      else if (bus.mem_en) n_busy++;
    end
    chk("tmo done seen", {63'd0, got_done}, 64'd1);
    chk("tmo busy cycles", 64'(n_busy), 64'd16);
    chk("tmo d_rdata", bus.d_rdata, 64'd0);
    chk("tmo err", {63'd0, bus.timeout_err}, 64'd1);
    bus.d_req = 1'b0;
    repeat (3) @(negedge clock);
    chk("tmo err sticky", {63'd0, bus.timeout_err}, 64'd1);

    // Asynchronous reset in the middle of a fetch.
    bus.if_req = 1'b1; bus.if_addr = 64'h80;
    repeat (2) @(negedge clock);
    chk("rstb busy", {63'd0, bus.mem_en}, 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("rstb en now", {63'd0, bus.mem_en}, 64'd0);
    chk("rstb err clr", {63'd0, bus.timeout_err}, 64'd0);
    @(negedge clock);
    bus.if_req = 1'b0; bus.mem_ready = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("rstb no done", {63'd0, bus.if_done}, 64'd0);
      chk("rstb idle", {63'd0, bus.mem_en}, 64'd0);
    end

    // Randomized traffic; phases vary memory readiness to reach timeouts.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      mode = (c / 500) % 3;
      if (bus.if_done) bus.if_req = 1'b0;
      else if (!bus.if_req) bus.if_req = ($urandom_range(0, 2) == 0);
      else if ($urandom_range(0, 31) == 0) bus.if_req = 1'b0;
      if (bus.d_done) bus.d_req = 1'b0;
      else if (!bus.d_req) bus.d_req = ($urandom_range(0, 2) == 0);
      else if ($urandom_range(0, 31) == 0) bus.d_req = 1'b0;
      bus.if_addr = {$urandom, $urandom};
      bus.d_addr  = {$urandom, $urandom};
      bus.d_wdata = {$urandom, $urandom};
      bus.d_we    = $urandom_range(0, 1) == 1;
      bus.mem_rdata = {$urandom, $urandom};
      if (mode == 0) bus.mem_ready = ($urandom_range(0, 1) == 0);
      else if (mode == 1) bus.mem_ready = ($urandom_range(0, 4) == 0);
      else bus.mem_ready = ($urandom_range(0, 39) == 0);
    end

    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
